// File: rtl/dmem_ctrl.sv
// dmem_ctrl: memory-side responder of the coherence bus; issues tagged memory txns and returns fills
module dmem_ctrl #(
  parameter int RSP_Q_PTR_W         = 3,
  parameter int MEM_TAG_W           = 4,
  parameter int TBL_NUM             = 16,
  parameter int DCACHE_TAG_W        = 20,
  parameter int DCACHE_IDX_W        = 5,
  parameter int DCACHE_WORD_IN_BITS = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bus_req_id_i,
  input  logic [DCACHE_TAG_W-1:0]        bus_req_tag_i,
  input  logic [DCACHE_IDX_W-1:0]        bus_req_idx_i,
  input  logic [1:0]                     bus_req_message_i,
  input  logic [DCACHE_WORD_IN_BITS-1:0] bus_req_data_i,
  input  logic                           bus_core_rsp_vld_i,
  input  logic                           bus_rsp_stall_i,
  input  logic [RSP_Q_PTR_W-1:0]         bus2Dmem_ctrl_rsp_ptr_i,
  output logic                           Dmem_ctrl_rsp_ack_o,
  output logic                           Dmem_ctrl_rsp_vld_o,
  output logic [RSP_Q_PTR_W-1:0]         Dmem_ctrl_rsp_ptr_o,
  output logic [DCACHE_WORD_IN_BITS-1:0] Dmem_ctrl_rsp_data_o,
  output logic [1:0]                     Dmem_ctrl2mem_command_o,
  output logic [63:0]                    Dmem_ctrl2mem_addr_o,
  output logic [63:0]                    Dmem_ctrl2mem_data_o,
  input  logic [MEM_TAG_W-1:0]           mem2Dmem_ctrl_response_i,
  input  logic [63:0]                    mem2Dmem_ctrl_data_i,
  input  logic [MEM_TAG_W-1:0]           mem2Dmem_ctrl_tag_i
);
  localparam logic [1:0] MSG_NONE  = 2'd0;
  localparam logic [1:0] GET_S     = 2'd1;
  localparam logic [1:0] GET_M     = 2'd2;
  localparam logic [1:0] PUT_M     = 2'd3;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int CNT_W = $clog2(TBL_NUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TBL_NUM - 1);
  logic [TBL_NUM-1:0]     tbl_vld;
  logic [RSP_Q_PTR_W-1:0] tbl_ptr [TBL_NUM];
  logic [CNT_W-1:0]       outstanding;
  logic                   is_load;
  logic                   is_store;
  logic                   eligible;
  logic                   alloc;
  logic                   ret_hit;
  logic                   unused;
  assign unused = bus_req_id_i;
  // issue decision, command mapping and same-cycle ack
  always_comb begin
    is_store                = bus_req_message_i == PUT_M;
    is_load                 = bus_req_message_i == GET_S || bus_req_message_i == GET_M;
    eligible                = rst && bus_req_message_i != MSG_NONE && !bus_core_rsp_vld_i &&
                              !bus_rsp_stall_i && (is_store || outstanding != CNT_MAX);
    Dmem_ctrl_rsp_ack_o     = eligible && mem2Dmem_ctrl_response_i != '0;
    alloc                   = Dmem_ctrl_rsp_ack_o && is_load;
    ret_hit                 = rst && mem2Dmem_ctrl_tag_i != '0 && tbl_vld[mem2Dmem_ctrl_tag_i];
    Dmem_ctrl2mem_command_o = !eligible ? BUS_NONE : is_store ? BUS_STORE : BUS_LOAD;
    Dmem_ctrl2mem_addr_o    = rst ? 64'({bus_req_tag_i, bus_req_idx_i, 3'b000}) : 64'd0;
    Dmem_ctrl2mem_data_o    = eligible && is_store ? 64'(bus_req_data_i) : 64'd0;
  end
  // tag table: a return clears the old entry first so a same-tag allocation wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      tbl_vld <= '0;
      for (int i = 0; i < TBL_NUM; i++) tbl_ptr[i] <= '0;
    end else begin
      if (ret_hit) tbl_vld[mem2Dmem_ctrl_tag_i] <= 1'b0;
      if (alloc) begin
        tbl_vld[mem2Dmem_ctrl_response_i] <= 1'b1;
        tbl_ptr[mem2Dmem_ctrl_response_i] <= bus2Dmem_ctrl_rsp_ptr_i;
      end
    end
  end
  // outstanding-load count, held when an alloc and a return coincide, never wraps
  always_ff @(posedge clk) begin
    if (!rst) outstanding <= '0;
    else outstanding <= (alloc && !ret_hit && outstanding != CNT_MAX) ? outstanding + 1'b1 :
                        (ret_hit && !alloc && outstanding != '0) ? outstanding - 1'b1 : outstanding;
  end
  // registered fill response toward the bus response queue
  always_ff @(posedge clk) begin
    if (!rst) begin
      Dmem_ctrl_rsp_vld_o  <= 1'b0;
      Dmem_ctrl_rsp_ptr_o  <= '0;
      Dmem_ctrl_rsp_data_o <= '0;
    end else begin
      Dmem_ctrl_rsp_vld_o <= ret_hit;
      if (ret_hit) begin
        Dmem_ctrl_rsp_ptr_o  <= tbl_ptr[mem2Dmem_ctrl_tag_i];
        Dmem_ctrl_rsp_data_o <= DCACHE_WORD_IN_BITS'(mem2Dmem_ctrl_data_i);
      end
    end
  end
  // flag memory returns that name a tag with no outstanding load
  always_ff @(posedge clk) begin
    if (rst && mem2Dmem_ctrl_tag_i != '0)
      orphan_return: assert (tbl_vld[mem2Dmem_ctrl_tag_i])
        else $warning("dmem_ctrl: return on idle tag %0d ignored", mem2Dmem_ctrl_tag_i);
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed stimulus with a behavioural model and per-cycle comparison
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_id = 1'b0;
  logic [19:0] req_tag = '0;
  logic [4:0]  req_idx = '0;
  logic [1:0]  req_msg = '0;
  logic [63:0] req_data = '0;
  logic        core_vld = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  ptr_in = '0;
  logic [3:0]  resp = '0;
  logic [63:0] mdata = '0;
  logic [3:0]  mtag = '0;
  logic        ack, rsp_vld;
  logic [2:0]  rsp_ptr;
  logic [63:0] rsp_data, maddr, mdata_out;
  logic [1:0]  cmd;
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  bit         m_vld [16];
  logic [2:0] m_ptr [16];
  logic       e_vld = 1'b0;
  logic [2:0] e_ptr = '0;
  logic [63:0] e_data = '0;

  dmem_ctrl #(.RSP_Q_PTR_W(3), .MEM_TAG_W(4), .TBL_NUM(16), .DCACHE_TAG_W(20),
              .DCACHE_IDX_W(5), .DCACHE_WORD_IN_BITS(64)) dut (
    .clk(clk), .rst(rst), .bus_req_id_i(req_id), .bus_req_tag_i(req_tag),
    .bus_req_idx_i(req_idx), .bus_req_message_i(req_msg), .bus_req_data_i(req_data),
    .bus_core_rsp_vld_i(core_vld), .bus_rsp_stall_i(stall), .bus2Dmem_ctrl_rsp_ptr_i(ptr_in),
    .Dmem_ctrl_rsp_ack_o(ack), .Dmem_ctrl_rsp_vld_o(rsp_vld), .Dmem_ctrl_rsp_ptr_o(rsp_ptr),
    .Dmem_ctrl_rsp_data_o(rsp_data), .Dmem_ctrl2mem_command_o(cmd),
    .Dmem_ctrl2mem_addr_o(maddr), .Dmem_ctrl2mem_data_o(mdata_out),
    .mem2Dmem_ctrl_response_i(resp), .mem2Dmem_ctrl_data_i(mdata), .mem2Dmem_ctrl_tag_i(mtag));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic int pending();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_vld[i]);
    return c;
  endfunction

  function automatic bit can_issue();
    return rst && req_msg != 2'd0 && !core_vld && !stall && (req_msg == 2'd3 || pending() < 15);
  endfunction

  initial for (int i = 0; i < 16; i++) begin m_vld[i] = 1'b0; m_ptr[i] = '0; end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
      e_vld = 1'b0; e_ptr = '0; e_data = '0;
    end else begin
      automatic bit load_ack = can_issue() && resp != 0 && req_msg != 2'd3;
      e_vld = mtag != 0 && m_vld[mtag];
      if (e_vld) begin
        e_ptr = m_ptr[mtag]; e_data = mdata; m_vld[mtag] = 1'b0;
      end
      if (load_ack) begin
        m_vld[resp] = 1'b1; m_ptr[resp] = ptr_in;
      end
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      automatic bit e = can_issue();
      chk("ack", 64'(ack), 64'(e && resp != 0));
      chk("command", 64'(cmd), !e ? 64'd0 : req_msg == 2'd3 ? 64'd2 : 64'd1);
      chk("addr", maddr, rst ? (64'(req_tag) << 8) + (64'(req_idx) << 3) : 64'd0);
      chk("store_data", mdata_out, (e && req_msg == 2'd3) ? req_data : 64'd0);
      chk("rsp_vld", 64'(rsp_vld), 64'(e_vld));
      chk("rsp_ptr", 64'(rsp_ptr), 64'(e_ptr));
      chk("rsp_data", rsp_data, e_data);
    end
  end

  task automatic step(input logic rs, input logic [1:0] m, input logic [19:0] t, input logic [4:0] i,
                      input logic [63:0] d, input logic [3:0] r, input logic [2:0] p,
                      input logic [3:0] mt, input logic [63:0] md, input logic cv, input logic st);
    @(posedge clk);
    #1;
    rst = rs; req_msg = m; req_tag = t; req_idx = i; req_data = d; resp = r; ptr_in = p;
    mtag = mt; mdata = md; core_vld = cv; stall = st;
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] mt, input logic [63:0] md);
    step(1, 0, 0, 0, 0, 0, 0, mt, md, 0, 0);
  endtask

  initial begin
    repeat (2) begin
      step(0, 1, 20'h12, 3, 0, 5, 2, 0, 0, 0, 0);
      chk("lit_reset_cmd", 64'(cmd), 0);
      chk("lit_reset_addr", maddr, 0);
      chk("lit_reset_rsp_vld", 64'(rsp_vld), 0);
    end
    step(1, 1, 20'h12, 3, 0, 5, 2, 0, 0, 0, 0);
    chk("lit_gets_ack", 64'(ack), 1);
    chk("lit_gets_cmd", 64'(cmd), 1);
    chk("lit_gets_addr", maddr, 64'h1218);
    idle(0, 0);
    chk("lit_no_early_rsp", 64'(rsp_vld), 0);
    idle(5, 64'hDEAD);
    chk("lit_rsp_latency", 64'(rsp_vld), 0);
    idle(0, 0);
    chk("lit_fill_vld", 64'(rsp_vld), 1);
    chk("lit_fill_ptr", 64'(rsp_ptr), 2);
    chk("lit_fill_data", rsp_data, 64'hDEAD);
    idle(0, 0);
    chk("lit_fill_pulse", 64'(rsp_vld), 0);
    step(1, 3, 20'h40, 1, 64'hBEEF, 7, 0, 0, 0, 0, 0);
    chk("lit_putm_ack", 64'(ack), 1);
    chk("lit_putm_cmd", 64'(cmd), 2);
    chk("lit_putm_data", mdata_out, 64'hBEEF);
    idle(7, 64'h77);
    idle(0, 0);
    chk("lit_putm_no_fill", 64'(rsp_vld), 0);
    step(1, 1, 20'h5, 2, 0, 3, 1, 0, 0, 1, 0);
    chk("lit_core_cmd", 64'(cmd), 0);
    chk("lit_core_ack", 64'(ack), 0);
    step(1, 2, 20'h5, 2, 0, 3, 1, 0, 0, 0, 1);
    chk("lit_stall_cmd", 64'(cmd), 0);
    chk("lit_stall_ack", 64'(ack), 0);
    repeat (3) begin
      step(1, 2, 20'h6, 4, 0, 0, 5, 0, 0, 0, 0);
      chk("lit_noresp_ack", 64'(ack), 0);
    end
    step(1, 2, 20'h6, 4, 0, 4, 5, 0, 0, 0, 0);
    chk("lit_retry_ack", 64'(ack), 1);
    idle(4, 64'h44);
    idle(0, 0);
    chk("lit_retry_fill_ptr", 64'(rsp_ptr), 5);
    for (int t = 1; t <= 15; t++) begin
      step(1, 1, 20'(t), 0, 0, 4'(t), 3'(t), 0, 0, 0, 0);
      chk("lit_fill_table_ack", 64'(ack), 1);
    end
    step(1, 1, 20'h99, 0, 0, 9, 0, 0, 0, 0, 0);
    chk("lit_full_cmd", 64'(cmd), 0);
    chk("lit_full_ack", 64'(ack), 0);
    step(1, 3, 20'h99, 0, 64'hCAFE, 1, 0, 0, 0, 0, 0);
    chk("lit_full_putm_ack", 64'(ack), 1);
    step(1, 1, 20'h99, 0, 0, 3, 6, 3, 64'h33, 0, 0);
    chk("lit_full_held_ack", 64'(ack), 0);
    step(1, 1, 20'h99, 0, 0, 3, 6, 0, 0, 0, 0);
    chk("lit_resume_ack", 64'(ack), 1);
    chk("lit_resume_rsp_ptr", 64'(rsp_ptr), 3);
    idle(5, 64'h5);
    step(1, 1, 20'h9A, 0, 0, 5, 7, 6, 64'h66, 0, 0);
    chk("lit_alloc_ret_ack", 64'(ack), 1);
    step(1, 1, 20'h9B, 0, 0, 4, 1, 4, 64'h4444, 0, 0);
    chk("lit_same_tag_ack", 64'(ack), 1);
    chk("lit_tag6_ptr", 64'(rsp_ptr), 6);
    idle(4, 64'h55);
    chk("lit_old_entry_ptr", 64'(rsp_ptr), 4);
    chk("lit_old_entry_data", rsp_data, 64'h4444);
    idle(0, 0);
    chk("lit_new_entry_ptr", 64'(rsp_ptr), 1);
    chk("lit_new_entry_data", rsp_data, 64'h55);
    step(0, 0, 0, 0, 0, 0, 0, 1, 64'h11, 0, 0);
    chk("lit_midreset_vld", 64'(rsp_vld), 0);
    idle(2, 64'h22);
    chk("lit_post_reset_vld", 64'(rsp_vld), 0);
    idle(3, 64'h33);
    chk("lit_drop_vld", 64'(rsp_vld), 0);
    idle(0, 0);
    chk("lit_drop_vld2", 64'(rsp_vld), 0);
    chk("lit_drop_ptr", 64'(rsp_ptr), 0);
    chk("lit_drop_data", rsp_data, 0);
    step(1, 1, 20'h1, 0, 0, 2, 0, 0, 0, 0, 0);
    chk("lit_recover_ack", 64'(ack), 1);
    repeat (3) idle(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
